main_controller: RTL and testbench

MAIN_CONTROLLER -- requirements
Module: main_controller

---
 rtl/main_controller_pkg.sv | 84 ++++++++
 rtl/main_controller.sv | 175 +++++++++++++++++
 tb/tb_main_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/main_controller_pkg.sv
// Shared decode constants for the multicycle controller: opcodes, funct codes, alu_op encodings, FSM states.
// The ALU controller imports the same alu_op constants so both ends agree on the encoding.
package main_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL_WB   = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_XORI);
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
               (op == OP_JAL) || is_itype(op);
    endfunction

    function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
        logic [2:0] r;
        case (op)
            OP_SLTI: r = ALU_SLT;
            OP_ANDI: r = ALU_AND;
            OP_ORI:  r = ALU_OR;
            OP_XORI: r = ALU_XOR;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/main_controller.sv
// Multicycle MIPS-style main controller: Moore FSM, 3-5 cycles per instruction with zero-wait memory.
// FETCH, MEM_RD and MEM_WR hold while mem_ready is low; every other state advances unconditionally.
module main_controller
    import main_controller_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_read,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic [1:0] reg_dst,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal_op
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       ready;
    ctrl_t      ctrl;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_FETCH;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_nxt = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    state_nxt = (funct == FN_JR) ? S_JR : S_R_EXEC;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_nxt = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_nxt = S_JUMP;
                end else if (opcode == OP_JAL) begin
                    state_nxt = S_JAL_WB;
                end else if (is_itype(opcode)) begin
                    state_nxt = S_I_EXEC;
                end
            end
            // IR is frozen outside FETCH, so opcode still identifies lw vs sw here.
            S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (ready) state_nxt = S_FETCH;
            end
            S_R_EXEC: state_nxt = S_R_WB;
            S_I_EXEC: state_nxt = S_I_WB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = ready;
                ctrl.pc_write  = ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = 2'b11;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_known_op(opcode);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 2'b00;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 2'b01;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = itype_alu_op(opcode);
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 2'b00;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = 2'b00;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.branch_ne     = (opcode == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            S_JAL_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 2'b10;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b11;
            end
            default: ctrl = '0;
        endcase
    end

    // State already sits in FETCH during reset; only the write strobes need masking.
    assign pc_write      = ctrl.pc_write & ~rst;
    assign pc_write_cond = ctrl.pc_write_cond & ~rst;
    assign ir_write      = ctrl.ir_write & ~rst;
    assign reg_write     = ctrl.reg_write & ~rst;
    assign mem_write     = ctrl.mem_write & ~rst;
    assign illegal_op    = ctrl.illegal_op & ~rst;
    assign mem_read      = ctrl.mem_read;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign branch_ne     = ctrl.branch_ne;
    assign pc_source     = ctrl.pc_source;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;

endmodule

// File: tb/tb_main_controller.sv
// Bench for main_controller: per-instruction expected output traces built from the instruction class,
// compared against the DUT every cycle, plus literal latency, strobe-count and reset checks.
module tb_main_controller;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, reg_write, mem_write;
    logic       mem_read, i_or_d, mem_to_reg, alu_src_a, branch_ne;
    logic [1:0] pc_source, reg_dst, alu_src_b;
    logic [2:0] alu_op;
    logic       illegal_op;

    main_controller #(.MEM_HANDSHAKE(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
        .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .branch_ne(branch_ne), .pc_source(pc_source), .reg_dst(reg_dst),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    ov_t exp_q[$];
    bit  rdy_q[$];
    int  cyc, n_regw, n_memw, n_ill, regw_cyc;

    function automatic ov_t act();
        ov_t v;
        v.pc_write = pc_write;   v.pc_write_cond = pc_write_cond; v.ir_write = ir_write;
        v.reg_write = reg_write; v.mem_write = mem_write;         v.mem_read = mem_read;
        v.i_or_d = i_or_d;       v.mem_to_reg = mem_to_reg;       v.alu_src_a = alu_src_a;
        v.branch_ne = branch_ne; v.pc_source = pc_source;         v.reg_dst = reg_dst;
        v.alu_src_b = alu_src_b; v.alu_op = alu_op;               v.illegal_op = illegal_op;
        return v;
    endfunction

    function automatic ov_t fetch_idle();
        ov_t v = '0;
        v.mem_read  = 1'b1;
        v.alu_src_b = 2'b01;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic chk_vec(input string name, input ov_t got, input ov_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: outputs got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push(input ov_t v, input bit r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    // Expected trace for one instruction: one entry per clock, with the mem_ready to present.
    // Non-memory steps drive mem_ready=0 to show it is ignored there.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        ov_t v;
        bit  known;
        known = op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                           6'b000010, 6'b000011, 6'b001000, 6'b001010, 6'b001100,
                           6'b001101, 6'b001110};
        for (int i = 0; i < fw; i++) push(fetch_idle(), 1'b0);
        v = fetch_idle(); v.pc_write = 1'b1; v.ir_write = 1'b1; push(v, 1'b1);
        v = '0; v.alu_src_b = 2'b11; v.illegal_op = !known; push(v, 1'b0);
        case (op)
            6'b100011, 6'b101011: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; push(v, 1'b0);
                if (op == 6'b100011) begin
                    v = '0; v.mem_read = 1'b1; v.i_or_d = 1'b1;
                    for (int i = 0; i <= mw; i++) push(v, i == mw);
                    v = '0; v.reg_write = 1'b1; v.mem_to_reg = 1'b1; push(v, 1'b0);
                end else begin
                    v = '0; v.mem_write = 1'b1; v.i_or_d = 1'b1;
                    for (int i = 0; i <= mw; i++) push(v, i == mw);
                end
            end
            6'b000000: begin
                if (fn == 6'b001000) begin
                    v = '0; v.pc_write = 1'b1; v.pc_source = 2'b11; push(v, 1'b0);
                end else begin
                    v = '0; v.alu_src_a = 1'b1; v.alu_op = 3'b010; push(v, 1'b0);
                    v = '0; v.reg_write = 1'b1; v.reg_dst = 2'b01; push(v, 1'b0);
                end
            end
            6'b000100, 6'b000101: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_op = 3'b001; v.pc_write_cond = 1'b1;
                v.pc_source = 2'b01; v.branch_ne = (op == 6'b000101); push(v, 1'b0);
            end
            6'b000010: begin
                v = '0; v.pc_write = 1'b1; v.pc_source = 2'b10; push(v, 1'b0);
            end
            6'b000011: begin
                v = '0; v.reg_write = 1'b1; v.reg_dst = 2'b10; v.pc_write = 1'b1;
                v.pc_source = 2'b10; push(v, 1'b0);
            end
            6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
                case (op)
                    6'b001010: v.alu_op = 3'b011;
                    6'b001100: v.alu_op = 3'b100;
                    6'b001101: v.alu_op = 3'b101;
                    6'b001110: v.alu_op = 3'b110;
                    default:   v.alu_op = 3'b000;
                endcase
                push(v, 1'b0);
                v = '0; v.reg_write = 1'b1; push(v, 1'b0);
            end
            default: ;
        endcase
    endtask

    // Called just after a falling edge; leaves at the next falling edge.
    task automatic step(input ov_t e, input bit r);
        ov_t a;
        mem_ready = r;
        #2;
        a = act();
        cyc++;
        if (a.reg_write) begin n_regw++; regw_cyc = cyc; end
        if (a.mem_write) n_memw++;
        if (a.illegal_op) n_ill++;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL trace op=%b cycle %0d: outputs got %h, expected %h", opcode, cyc, a, e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input int lat);
        opcode = op;
        funct  = fn;
        exp_q.delete();
        rdy_q.delete();
        build(op, fn, fw, mw);
        chk("latency", exp_q.size(), lat + fw + mw);
        cyc = 0; n_regw = 0; n_memw = 0; n_ill = 0; regw_cyc = 0;
        while (exp_q.size() > 0) step(exp_q.pop_front(), rdy_q.pop_front());
    endtask

    // Runs nsteps of an instruction whose memory phase stalls, then asserts reset mid-cycle.
    task automatic abort_at(input logic [5:0] op, input int nsteps);
        opcode = op;
        funct  = 6'b000000;
        exp_q.delete();
        rdy_q.delete();
        build(op, 6'b000000, 0, 5);
        cyc = 0; n_regw = 0; n_memw = 0; n_ill = 0; regw_cyc = 0;
        for (int i = 0; i < nsteps; i++) step(exp_q.pop_front(), rdy_q.pop_front());
        exp_q.delete();
        rdy_q.delete();
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk_vec("abort_same_cycle", act(), fetch_idle());
        @(posedge clk);
        @(negedge clk);
        chk_vec("abort_held", act(), fetch_idle());
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        funct = 6'b000000;
        #3;
        chk_vec("reset_outs", act(), fetch_idle());
        @(posedge clk);
        @(negedge clk);
        chk_vec("reset_outs_after_edge", act(), fetch_idle());
        rst = 1'b0;

        run(6'b100011, 6'b000000, 0, 0, 5);
        chk("lw_regwrite_cycle", regw_cyc, 5);
        chk("lw_regwrite_count", n_regw, 1);
        run(6'b100011, 6'b000000, 2, 1, 5);
        run(6'b101011, 6'b000000, 0, 3, 4);
        chk("sw_memwrite_cycles", n_memw, 4);
        chk("sw_no_regwrite", n_regw, 0);
        run(6'b000000, 6'b100010, 0, 0, 4);
        chk("rtype_regwrite_cycle", regw_cyc, 4);
        run(6'b000000, 6'b001000, 0, 0, 3);
        chk("jr_no_regwrite", n_regw, 0);
        run(6'b000100, 6'b000000, 0, 0, 3);
        run(6'b000101, 6'b000000, 0, 0, 3);
        run(6'b000010, 6'b000000, 1, 0, 3);
        run(6'b000011, 6'b000000, 0, 0, 3);
        chk("jal_regwrite_cycle", regw_cyc, 3);
        run(6'b001000, 6'b000000, 0, 0, 4);
        run(6'b001010, 6'b000000, 0, 0, 4);
        run(6'b001100, 6'b000000, 0, 0, 4);
        run(6'b001101, 6'b000000, 0, 0, 4);
        run(6'b001110, 6'b000000, 0, 0, 4);
        run(6'b111111, 6'b000000, 0, 0, 2);
        chk("illegal_pulse_cycles", n_ill, 1);
        chk("illegal_no_writes", n_regw + n_memw, 0);
        run(6'b010000, 6'b000000, 0, 0, 2);
        chk("illegal2_pulse_cycles", n_ill, 1);

        abort_at(6'b100011, 4);
        chk("abort_rd_no_regwrite", n_regw, 0);
        run(6'b001000, 6'b000000, 0, 0, 4);
        abort_at(6'b101011, 4);
        chk("abort_wr_memwrite_before", n_memw, 1);
        run(6'b100011, 6'b000000, 0, 0, 5);
        chk("post_abort_lw_regwrite", regw_cyc, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
